// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state numbering,
// opcode values, datapath mux-select codes and the bundled control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       aluout_we;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath. Only the state is
// registered; every control output is decoded from state, opcode and mem_ready.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  input  logic                    zero,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mem_to_reg,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic                    aluout_we,
  output logic                    illegal_op,
  output logic [STATE_WIDTH-1:0]  state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // The branch comparison is applied in the datapath PC gate, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_R:                      state_d = S_EXECUTE;
          OP_BEQ:                    state_d = S_BRANCH;
          OP_J:                      state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMM_EXEC;
          default:                   state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_IMM_EXEC:  state_d = S_IMM_WB;
      S_MEM_WB, S_R_WB, S_IMM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Gating on rst_n keeps FETCH's memory read and every write enable low
  // while reset is held, even though the state already reads FETCH.
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_BR;
          ctrl.aluout_we = 1'b1;
          case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI: ctrl.illegal_op = 1'b0;
            default:                  ctrl.illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.aluout_we = 1'b1;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_FUNCT;
          ctrl.aluout_we = 1'b1;
        end
        S_R_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_IMM_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.aluout_we = 1'b1;
          ctrl.alu_op    = (opcode == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
        end
        S_IMM_WB:    ctrl.reg_write = 1'b1;
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCS_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_JUMP;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign aluout_we     = ctrl.aluout_we;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push
// hand-derived per-cycle expectations; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, aluout_we, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .aluout_we(aluout_we), .illegal_op(illegal_op),
    .state(state)
  );

  // Field order: pw pwc iord mr mw irw m2r rw rd asa asb aop pcs awe ill
  function automatic logic [17:0] mk(input logic pw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa,
                                     input logic [1:0] asb, aop, pcs, input logic awe, ill);
    return {pw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa, asb, aop, pcs, awe, ill};
  endfunction

  logic [17:0] V_ZERO, V_FETCH_RDY, V_FETCH_WAIT, V_DECODE, V_DECODE_ILL, V_MEM_ADDR;
  logic [17:0] V_MEM_READ, V_MEM_WRITE, V_MEM_WB, V_EXECUTE, V_R_WB, V_IMM_ADD;
  logic [17:0] V_IMM_LOGIC, V_IMM_WB, V_BRANCH, V_JUMP;

  initial begin
    V_ZERO       = '0;
    V_FETCH_RDY  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    V_FETCH_WAIT = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    V_DECODE     = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,0);
    V_DECODE_ILL = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,1);
    V_MEM_ADDR   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,1,0);
    V_MEM_READ   = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    V_MEM_WRITE  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    V_MEM_WB     = mk(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,0);
    V_EXECUTE    = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,1,0);
    V_R_WB       = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
    V_IMM_ADD    = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,1,0);
    V_IMM_LOGIC  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,1,0);
    V_IMM_WB     = mk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0);
    V_BRANCH     = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
    V_JUMP       = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0);
  end

  // Monitor: every cycle the DUT presents a control word; compare mid-cycle.
  initial begin
    exp_t e;
    logic [17:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = mk(pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, aluout_we,
                 illegal_op);
        n_checks++;
        if (state !== e.st || act !== e.v) begin
          n_fail++;
          $display("FAIL %s: state=%0d ctrl=%b, required state=%0d ctrl=%b",
                   e.name, state, act, e.st, e.v);
        end else begin
          $display("ok   %s: state=%0d ctrl=%b", e.name, state, act);
        end
      end
    end
  end

  // Drive inputs for one cycle, queue that cycle's expectation, advance.
  task automatic step(input string name, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [17:0] v);
    exp_t e;
    opcode    = op;
    mem_ready = rdy;
    e.name = name; e.st = st; e.v = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
    @(posedge clk); #1;
    step("reset_idle", 6'b000000, 1'b1, 4'd0, V_ZERO);
    rst_n = 1'b1;

    // R-type, decode sees mem_ready low (must be ignored)
    step("r_fetch",   6'b000000, 1'b1, 4'd0, V_FETCH_RDY);
    step("r_decode",  6'b000000, 1'b0, 4'd1, V_DECODE);
    step("r_execute", 6'b000000, 1'b1, 4'd6, V_EXECUTE);
    step("r_wb",      6'b000000, 1'b1, 4'd7, V_R_WB);

    // LW with two wait cycles in MEM_READ
    step("lw_fetch",  6'b100011, 1'b1, 4'd0, V_FETCH_RDY);
    step("lw_decode", 6'b100011, 1'b1, 4'd1, V_DECODE);
    step("lw_addr",   6'b100011, 1'b1, 4'd2, V_MEM_ADDR);
    step("lw_read_w1",6'b100011, 1'b0, 4'd3, V_MEM_READ);
    step("lw_read_w2",6'b100011, 1'b0, 4'd3, V_MEM_READ);
    step("lw_read_ok",6'b100011, 1'b1, 4'd3, V_MEM_READ);
    step("lw_wb",     6'b100011, 1'b1, 4'd4, V_MEM_WB);

    // SW, one wait cycle in MEM_WRITE
    step("sw_fetch",  6'b101011, 1'b1, 4'd0, V_FETCH_RDY);
    step("sw_decode", 6'b101011, 1'b1, 4'd1, V_DECODE);
    step("sw_addr",   6'b101011, 1'b1, 4'd2, V_MEM_ADDR);
    step("sw_write_w",6'b101011, 1'b0, 4'd5, V_MEM_WRITE);
    step("sw_write",  6'b101011, 1'b1, 4'd5, V_MEM_WRITE);

    // BEQ and J
    step("beq_fetch", 6'b000100, 1'b1, 4'd0, V_FETCH_RDY);
    step("beq_decode",6'b000100, 1'b1, 4'd1, V_DECODE);
    step("beq_branch",6'b000100, 1'b1, 4'd8, V_BRANCH);
    step("j_fetch",   6'b000010, 1'b1, 4'd0, V_FETCH_RDY);
    step("j_decode",  6'b000010, 1'b1, 4'd1, V_DECODE);
    step("j_jump",    6'b000010, 1'b1, 4'd9, V_JUMP);

    // Immediate ops
    step("andi_fetch", 6'b001100, 1'b1, 4'd0,  V_FETCH_RDY);
    step("andi_decode",6'b001100, 1'b1, 4'd1,  V_DECODE);
    step("andi_exec",  6'b001100, 1'b1, 4'd10, V_IMM_LOGIC);
    step("andi_wb",    6'b001100, 1'b1, 4'd11, V_IMM_WB);
    step("addi_fetch", 6'b001000, 1'b1, 4'd0,  V_FETCH_RDY);
    step("addi_decode",6'b001000, 1'b1, 4'd1,  V_DECODE);
    step("addi_exec",  6'b001000, 1'b1, 4'd10, V_IMM_ADD);
    step("addi_wb",    6'b001000, 1'b1, 4'd11, V_IMM_WB);
    step("ori_fetch",  6'b001101, 1'b1, 4'd0,  V_FETCH_RDY);
    step("ori_decode", 6'b001101, 1'b1, 4'd1,  V_DECODE);
    step("ori_exec",   6'b001101, 1'b1, 4'd10, V_IMM_LOGIC);
    step("ori_wb",     6'b001101, 1'b1, 4'd11, V_IMM_WB);

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    step("ill_fetch",  6'b111111, 1'b1, 4'd0, V_FETCH_RDY);
    step("ill_decode", 6'b111111, 1'b1, 4'd1, V_DECODE_ILL);

    // FETCH stalled three cycles, then an R-type reset during EXECUTE
    step("fw_wait1",   6'b000000, 1'b0, 4'd0, V_FETCH_WAIT);
    step("fw_wait2",   6'b000000, 1'b0, 4'd0, V_FETCH_WAIT);
    step("fw_wait3",   6'b000000, 1'b0, 4'd0, V_FETCH_WAIT);
    step("fw_ready",   6'b000000, 1'b1, 4'd0, V_FETCH_RDY);
    step("fw_decode",  6'b000000, 1'b1, 4'd1, V_DECODE);
    rst_n = 1'b0;
    step("rst_in_exec",6'b000000, 1'b1, 4'd0, V_ZERO);
    step("rst_held",   6'b000000, 1'b1, 4'd0, V_ZERO);
    rst_n = 1'b1;
    step("post_rst_fetch", 6'b000000, 1'b1, 4'd0, V_FETCH_RDY);
    step("post_rst_decode",6'b000000, 1'b1, 4'd1, V_DECODE);

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
